// File: rtl/sram22_port_ctrl_pkg.sv
// sram22_ctrl_pkg: shared types and constants for the sram22 port controller.
//   state_e        controller FSM states
//   RSP_DEPTH_DEF  default response-buffer depth (2 keeps reads at full rate)
//   RAM_DEPTH      word count of the 1024x32 macro
package sram22_ctrl_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int RSP_DEPTH_DEF  = 2;
  localparam int ADDR_WIDTH_DEF = 10;

  function automatic int ram_depth(input int aw);
    return 1 << aw;
  endfunction

  localparam int RAM_DEPTH = ram_depth(ADDR_WIDTH_DEF);

endpackage

// File: rtl/sram22_port_ctrl_if.sv
// sram22_port_ctrl_if: request/response streams between a client (master)
// and the sram22 port controller (slave).
//   req_valid/req_ready  request handshake; req_we/req_addr/req_wdata/req_wmask payload
//   rsp_valid/rsp_ready  read-response handshake; rsp_rdata payload
interface sram22_port_ctrl_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WMASK_WIDTH = 1
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic [WMASK_WIDTH-1:0] req_wmask;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DATA_WIDTH-1:0]  rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram22_port_ctrl_rsp_fifo.sv
// sram22_rsp_fifo: small synchronous FIFO holding read data until the
// consumer takes it.
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   i_push     write i_din (caller guarantees not full unless popping)
//   i_pop      drop head entry (caller guarantees not empty)
//   o_dout     head entry; stable while no pop
//   o_count    occupancy 0..DEPTH
module sram22_rsp_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_dout,
  output logic [CW-1:0] o_count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // The credit rule upstream makes both of these impossible.
  a_no_overflow:  assert property (@(posedge clk) disable iff (rst)
                    !(i_push && !i_pop && r_count == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
                    !(i_pop && r_count == '0));

endmodule

// File: rtl/sram22_port_ctrl.sv
// sram22_port_ctrl: initiator-side controller for the single-port sram22
// macro (1-cycle read latency).
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       request stream in, read-response stream out
//   init_done         high once the controller is in RUN
//   sram_we/wmask/addr/din  macro inputs; sram_dout macro read data
//   sram_sae_int      macro sense-amp enable, looped back on sram_sae_muxed
// After reset the macro is optionally zero-filled (one word per cycle), then
// requests drive the macro ports combinationally. Read data is captured one
// cycle after issue into a small response FIFO; reads are only accepted while
// a FIFO slot is guaranteed, so the FIFO never overflows.
module sram22_port_ctrl
  import sram22_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int WMASK_WIDTH    = 1,
  parameter int RSP_DEPTH      = RSP_DEPTH_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  sram22_port_ctrl_if.slave      bus,
  output logic                   init_done,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout,
  input  logic                   sram_sae_int,
  output logic                   sram_sae_muxed
);

  localparam int DEPTH = ram_depth(ADDR_WIDTH);
  localparam int CW    = $clog2(RSP_DEPTH + 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_rd_pend;
  logic                  r_init_done;
  logic [CW-1:0]         w_fifo_cnt;
  logic [CW:0]           w_occ;
  logic                  w_pop;
  logic                  w_rd_ok;
  logic                  w_rd_acc;
  logic                  w_clr_last;

  assign bus.rsp_valid = (w_fifo_cnt != '0);
  assign w_pop         = bus.rsp_valid & bus.rsp_ready;
  // Slots claimed after this edge: buffered + in flight - leaving now.
  // Counting the pop lets a full buffer still take a read each cycle.
  assign w_occ         = {1'b0, w_fifo_cnt} + (CW+1)'(r_rd_pend) - (CW+1)'(w_pop);
  assign w_rd_ok       = w_occ < (CW+1)'(RSP_DEPTH);
  assign w_rd_acc      = bus.req_valid & bus.req_ready & ~bus.req_we;
  assign w_clr_last    = (r_clr_cnt == ADDR_WIDTH'(DEPTH - 1));
  assign init_done     = r_init_done;
  assign sram_sae_muxed = sram_sae_int;

  always_ff @(posedge clk) begin
    if (rst) r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.req_ready = 1'b0;
    sram_we       = 1'b0;
    sram_wmask    = '0;
    sram_addr     = bus.req_addr;
    sram_din      = bus.req_wdata;
    unique case (r_state)
      ST_CLEAR: begin
        sram_we    = ~rst;
        sram_wmask = '1;
        sram_addr  = r_clr_cnt;
        sram_din   = '0;
        if (w_clr_last) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Writes never need a response slot; reads need a credit.
        bus.req_ready = ~rst & r_init_done & (bus.req_we | w_rd_ok);
        sram_wmask    = bus.req_wmask;
        sram_we       = bus.req_valid & bus.req_ready & bus.req_we;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_cnt   <= '0;
      r_rd_pend   <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_rd_pend   <= w_rd_acc;
      r_init_done <= (w_state_nxt == ST_RUN);
      if (r_state == ST_CLEAR && !w_clr_last) r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  // Data is captured the edge after issue, before any following write can
  // disturb sram_dout.
  sram22_rsp_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_rd_pend),
    .i_din   (sram_dout),
    .i_pop   (w_pop),
    .o_dout  (bus.rsp_rdata),
    .o_count (w_fifo_cnt)
  );

endmodule

// File: tb/tb_sram22_port_ctrl.sv
module tb_sram22_port_ctrl;
  import sram22_ctrl_pkg::*;

  localparam int DW = 32, AW = 10, MW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done, sram_we, sram_sae_int, sram_sae_muxed;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;

  sram22_port_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) u_if ();

  sram22_port_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW),
    .RSP_DEPTH(2), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bus(u_if), .init_done(init_done),
    .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout),
    .sram_sae_int(sram_sae_int), .sram_sae_muxed(sram_sae_muxed)
  );

  always #5 clk = ~clk;

  // Behavioural sram22 macro: 1-cycle read, dout garbage after a write.
  logic [DW-1:0] mac_mem [RAM_DEPTH];
  always @(posedge clk) begin
    if (sram_we) begin
      if (sram_wmask[0]) mac_mem[sram_addr] <= sram_din;
      sram_dout <= 32'hBAD0BAD0;
    end else begin
      sram_dout <= mac_mem[sram_addr];
    end
    if (rst) sram_sae_int <= 1'b0;
    else     sram_sae_int <= ~sram_sae_int;
  end

  // ---------------- reference model + compare ----------------
  typedef struct { logic [DW-1:0] data; int vis; } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [RAM_DEPTH];
  logic [DW-1:0] got_q[$];
  int k = 0, sweep = 0, n_cmp = 0, n_err = 0, rd_acc_cnt = 0;
  bit mdl_done = 1'b0, prev_rst = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (sample %0d)", nm, act, exp, k);
    end
  endtask

  always @(negedge clk) begin : cmp
    bit ev, pop, er, acc;
    chk("sae_loop", sram_sae_muxed, sram_sae_int);
    if (rst) begin
      chk("rst_we", sram_we, 0);
      if (prev_rst) begin
        chk("rst_rsp_valid", u_if.rsp_valid, 0);
        chk("rst_init_done", init_done, 0);
      end
      exp_q.delete();
      sweep    = 0;
      mdl_done = 1'b0;
    end else begin
      chk("init_done", init_done, mdl_done);
      if (!mdl_done) begin
        chk("clr_ready", u_if.req_ready, 0);
        chk("clr_we", sram_we, 1);
        chk("clr_addr", sram_addr, sweep);
        chk("clr_din", sram_din, 0);
        chk("clr_mask", sram_wmask, 1);
        chk("clr_rsp_valid", u_if.rsp_valid, 0);
        ref_mem[sweep] = '0;
        sweep++;
        if (sweep == RAM_DEPTH) mdl_done = 1'b1;
      end else begin
        ev = (exp_q.size() > 0) && (exp_q[0].vis <= k);
        chk("rsp_valid", u_if.rsp_valid, ev);
        if (ev) chk("rsp_rdata", u_if.rsp_rdata, exp_q[0].data);
        pop = ev && u_if.rsp_ready;
        er  = u_if.req_we ? 1'b1 : ((exp_q.size() - int'(pop)) < RSP_DEPTH_DEF);
        chk("req_ready", u_if.req_ready, er);
        acc = u_if.req_valid && er;
        chk("sram_we", sram_we, acc && u_if.req_we);
        if (acc) chk("sram_addr", sram_addr, u_if.req_addr);
        if (acc && u_if.req_we) begin
          chk("sram_din", sram_din, u_if.req_wdata);
          chk("sram_wmask", sram_wmask, u_if.req_wmask);
        end
        if (pop) begin
          got_q.push_back(u_if.rsp_rdata);
          void'(exp_q.pop_front());
        end
        if (acc) begin
          if (u_if.req_we) begin
            if (u_if.req_wmask[0]) ref_mem[u_if.req_addr] = u_if.req_wdata;
          end else begin
            exp_q.push_back('{data: ref_mem[u_if.req_addr], vis: k + 2});
            rd_acc_cnt++;
          end
        end
      end
    end
    prev_rst = rst;
    k++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input bit we, input int addr, input logic [31:0] d, input bit m);
    int t = 0;
    u_if.req_valid = 1'b1; u_if.req_we = we; u_if.req_addr = addr[AW-1:0];
    u_if.req_wdata = d;    u_if.req_wmask = m;
    do begin @(negedge clk); t++; end while (!u_if.req_ready && t < 200);
    if (!u_if.req_ready) chk("req_timeout", 0, 1);
    @(posedge clk); #1;
    u_if.req_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int t = 0;
    while (got_q.size() < n && t < 100) begin @(negedge clk); t++; end
    chk("rsp_timeout", got_q.size() >= n, 1);
  endtask

  task automatic wait_init(input bit check_len);
    int n = 0;
    while (!init_done && n < 2000) begin @(negedge clk); if (!init_done) n++; end
    if (check_len) chk("clear_len", n, 1024);
    else           chk("init_after_clear", init_done, 1);
    tick();
  endtask

  initial begin
    int t;
    u_if.req_valid = 1'b0; u_if.req_we = 1'b0; u_if.req_addr = '0;
    u_if.req_wdata = '0;   u_if.req_wmask = '0; u_if.rsp_ready = 1'b1;

    repeat (3) tick();
    chk("reset_init_done", init_done, 0);
    chk("reset_rsp_valid", u_if.rsp_valid, 0);
    chk("reset_req_ready", u_if.req_ready, 0);
    rst = 1'b0;
    wait_init(1'b1);

    // Cleared word reads back as zero.
    got_q.delete();
    send(0, 'h3FF, 0, 0);
    wait_got(1);
    chk("clr_word_3ff", got_q[0], 32'h0);

    // Write then read with 2-cycle latency.
    send(1, 'h005, 32'hDEADBEEF, 1);
    send(0, 'h005, 0, 0);
    @(negedge clk); chk("lat1_valid", u_if.rsp_valid, 0);
    @(negedge clk); chk("lat2_valid", u_if.rsp_valid, 1);
    chk("lat2_data", u_if.rsp_rdata, 32'hDEADBEEF);
    tick();

    // Masked-off write leaves the word alone.
    got_q.delete();
    send(1, 'h005, 32'h12345678, 0);
    send(0, 'h005, 0, 0);
    wait_got(1);
    chk("mask0_keeps", got_q[0], 32'hDEADBEEF);

    // Backpressure: only two reads accepted while rsp_ready=0.
    for (int i = 0; i < 4; i++) send(1, 10 + i, 32'h1000 + i, 1);
    got_q.delete();
    u_if.rsp_ready = 1'b0;
    t = rd_acc_cnt;
    fork
      begin for (int i = 0; i < 4; i++) send(0, 10 + i, 0, 0); end
      begin
        repeat (8) @(negedge clk);
        chk("bp_accepted", rd_acc_cnt - t, 2);
        chk("bp_ready_low", u_if.req_ready, 0);
        @(posedge clk); #1;
        u_if.rsp_ready = 1'b1;
      end
    join
    wait_got(4);
    for (int i = 0; i < 4; i++) chk("bp_order", got_q[i], 32'h1000 + i);

    // Read / write same address / read.
    send(1, 20, 32'hA5A5A5A5, 1);
    got_q.delete();
    send(0, 20, 0, 0);
    send(1, 20, 32'h5A5A5A5A, 1);
    send(0, 20, 0, 0);
    wait_got(2);
    chk("rwr_old", got_q[0], 32'hA5A5A5A5);
    chk("rwr_new", got_q[1], 32'h5A5A5A5A);

    // Randomized traffic over a small address window.
    for (int c = 0; c < 400; c++) begin
      u_if.req_valid = 1'($urandom_range(0, 1));
      u_if.req_we    = ($urandom_range(0, 3) == 0);
      u_if.req_addr  = AW'($urandom_range(0, 15));
      u_if.req_wdata = $urandom;
      u_if.req_wmask = MW'($urandom_range(0, 3) != 0);
      u_if.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    u_if.req_valid = 1'b0;
    u_if.rsp_ready = 1'b1;
    repeat (6) tick();

    // Reset with two buffered responses drops them.
    u_if.rsp_ready = 1'b0;
    send(0, 3, 0, 0);
    send(0, 4, 0, 0);
    repeat (3) tick();
    chk("buf_valid_before_rst", u_if.rsp_valid, 1);
    rst = 1'b1;
    tick();
    chk("rsp_valid_after_rst", u_if.rsp_valid, 0);
    rst = 1'b0;
    u_if.rsp_ready = 1'b1;

    // Reset mid-sweep restarts the sweep at address 0.
    t = 0;
    while (sram_addr != AW'('h200) && t < 2000) begin tick(); t++; end
    chk("reach_0x200", sram_addr, 'h200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("restart_addr", sram_addr, 0);
    chk("restart_we", sram_we, 1);
    wait_init(1'b0);

    got_q.delete();
    send(0, 'h200, 0, 0);
    send(0, 'h005, 0, 0);
    wait_got(2);
    chk("reclr_200", got_q[0], 32'h0);
    chk("reclr_005", got_q[1], 32'h0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
